// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with saturating direction counters and a return-address stack.
// Zero-latency combinational lookup; updates commit on the next CLK edge only when both caches are ready and FLUSH is low.
module btb_assoc #(
  parameter int ADDR_WIDTH = 64,
  parameter int SETS       = 256,
  parameter int WAYS       = 2,
  parameter int CTR_BITS   = 2,
  parameter int RAS_DEPTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [ADDR_WIDTH-1:0] PC,
  input  logic                  CACHE_READY,
  input  logic                  CACHE_READY_DATA,
  input  logic                  FLUSH,
  input  logic                  EX_BRANCH,
  input  logic                  EX_TAKEN,
  input  logic [ADDR_WIDTH-1:0] EX_PC,
  input  logic [ADDR_WIDTH-1:0] EX_TARGET,
  input  logic                  EX_CALL,
  input  logic                  EX_RETURN,
  input  logic                  EX_MISPREDICT,
  output logic                  PRD_HIT,
  output logic                  PRD_TAKEN,
  output logic [ADDR_WIDTH-1:0] PRD_ADDR,
  output logic [31:0]           BR_COUNT,
  output logic [31:0]           MISS_COUNT
);
  localparam int IDX   = $clog2(SETS);
  localparam int TAG_W = ADDR_WIDTH - IDX - 2;
  localparam int WPTR  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int RPTR  = $clog2(RAS_DEPTH);
  localparam int RCNT  = $clog2(RAS_DEPTH + 1);
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic [WAYS-1:0]       valid_q [SETS];
  logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
  logic [ADDR_WIDTH-1:0] tgt_q   [SETS][WAYS];
  logic                  ret_q   [SETS][WAYS];
  logic [CTR_BITS-1:0]   ctr_q   [SETS][WAYS];
  logic [WPTR-1:0]       vptr_q  [SETS];
  logic [ADDR_WIDTH-1:0] ras_q   [RAS_DEPTH];

  logic [RPTR-1:0] ras_ptr_q, ras_ptr_d;
  logic [RCNT-1:0] ras_cnt_q, ras_cnt_d;
  logic [31:0]     br_cnt_q, br_cnt_d, miss_cnt_q, miss_cnt_d;

  logic [IDX-1:0]   f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  logic             f_hit, e_hit, inv_found;
  logic [WPTR-1:0]  f_way, e_way, inv_way, w_way, vptr_d;
  logic             rdy, upd, tbl_we, vptr_we, ras_we, w_ret;
  logic [ADDR_WIDTH-1:0] w_tgt, ras_top, ras_wdat;
  logic [CTR_BITS-1:0]   w_ctr;
  logic [RPTR-1:0]       ras_wptr;
  logic                  unused_pc_lsbs;

  assign f_idx = PC[IDX+1:2];
  assign f_tag = PC[ADDR_WIDTH-1:IDX+2];
  assign e_idx = EX_PC[IDX+1:2];
  assign e_tag = EX_PC[ADDR_WIDTH-1:IDX+2];
  assign unused_pc_lsbs = ^{PC[1:0], EX_PC[1:0]};

  assign rdy     = CACHE_READY & CACHE_READY_DATA;
  assign upd     = EX_BRANCH & rdy & ~FLUSH & ~RST;
  assign ras_top = ras_q[ras_ptr_q - RPTR'(1)];

  always_comb begin
    f_hit = 1'b0;
    f_way = '0;
    e_hit = 1'b0;
    e_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[f_idx][w] && tag_q[f_idx][w] == f_tag) begin
        f_hit = 1'b1;
        f_way = WPTR'(w);
      end
      if (valid_q[e_idx][w] && tag_q[e_idx][w] == e_tag) begin
        e_hit = 1'b1;
        e_way = WPTR'(w);
      end
    end
  end

  always_comb begin
    PRD_HIT   = f_hit;
    PRD_TAKEN = 1'b0;
    PRD_ADDR  = PC + ADDR_WIDTH'(4);
    if (f_hit && ret_q[f_idx][f_way] && ras_cnt_q != '0) begin
      PRD_TAKEN = 1'b1;
      PRD_ADDR  = ras_top;
    end else if (f_hit && ctr_q[f_idx][f_way][CTR_BITS-1]) begin
      PRD_TAKEN = 1'b1;
      PRD_ADDR  = tgt_q[f_idx][f_way];
    end
  end

  // Table write: train on hit, allocate on taken miss (invalid way first, then round-robin).
  always_comb begin
    tbl_we    = 1'b0;
    vptr_we   = 1'b0;
    w_way     = e_way;
    w_ret     = ret_q[e_idx][e_way];
    w_tgt     = tgt_q[e_idx][e_way];
    w_ctr     = ctr_q[e_idx][e_way];
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[e_idx][w]) begin
        inv_found = 1'b1;
        inv_way   = WPTR'(w);
      end
    end
    vptr_d = (vptr_q[e_idx] == WPTR'(WAYS - 1)) ? '0 : vptr_q[e_idx] + WPTR'(1);
    if (upd && e_hit) begin
      tbl_we = 1'b1;
      if (EX_TAKEN) begin
        w_ctr = (w_ctr == CTR_MAX) ? w_ctr : w_ctr + CTR_BITS'(1);
      end else begin
        w_ctr = (w_ctr == '0) ? w_ctr : w_ctr - CTR_BITS'(1);
      end
      if (EX_TAKEN && w_tgt != EX_TARGET) begin
        w_tgt = EX_TARGET;
        w_ctr = CTR_INIT;
      end
    end else if (upd && EX_TAKEN) begin
      tbl_we = 1'b1;
      w_ret  = EX_RETURN;
      w_tgt  = EX_TARGET;
      w_ctr  = CTR_INIT;
      if (inv_found) begin
        w_way = inv_way;
      end else begin
        w_way   = vptr_q[e_idx];
        vptr_we = 1'b1;
      end
    end
  end

  // Circular RAS: a push when full overwrites the oldest slot; call+return rewrites the top in place.
  always_comb begin
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    ras_we    = 1'b0;
    ras_wptr  = ras_ptr_q;
    ras_wdat  = EX_PC + ADDR_WIDTH'(4);
    if (upd && EX_CALL && EX_RETURN) begin
      ras_we   = (ras_cnt_q != '0);
      ras_wptr = ras_ptr_q - RPTR'(1);
    end else if (upd && EX_CALL) begin
      ras_we    = 1'b1;
      ras_ptr_d = ras_ptr_q + RPTR'(1);
      if (ras_cnt_q != RCNT'(RAS_DEPTH)) ras_cnt_d = ras_cnt_q + RCNT'(1);
    end else if (upd && EX_RETURN && ras_cnt_q != '0) begin
      ras_ptr_d = ras_ptr_q - RPTR'(1);
      ras_cnt_d = ras_cnt_q - RCNT'(1);
    end
    br_cnt_d   = br_cnt_q + (upd ? 32'd1 : 32'd0);
    miss_cnt_d = miss_cnt_q + ((upd && EX_MISPREDICT) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        vptr_q[s]  <= '0;
      end
      ras_ptr_q  <= '0;
      ras_cnt_q  <= '0;
      br_cnt_q   <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (tbl_we) begin
        valid_q[e_idx][w_way] <= 1'b1;
        tag_q[e_idx][w_way]   <= e_tag;
        tgt_q[e_idx][w_way]   <= w_tgt;
        ret_q[e_idx][w_way]   <= w_ret;
        ctr_q[e_idx][w_way]   <= w_ctr;
      end
      if (vptr_we) vptr_q[e_idx] <= vptr_d;
      if (ras_we) ras_q[ras_wptr] <= ras_wdat;
      ras_ptr_q  <= ras_ptr_d;
      ras_cnt_q  <= ras_cnt_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign BR_COUNT   = br_cnt_q;
  assign MISS_COUNT = miss_cnt_q;
endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64: PC and target width.
REQ-002 SHALL have parameter SETS, default 256: set count, power of two >= 2; IDX = log2(SETS).
REQ-003 SHALL have parameter WAYS, default 2: associativity, 1..8.
REQ-004 SHALL have parameter CTR_BITS, default 2: saturating-counter width, 1..4.
REQ-005 SHALL have parameter RAS_DEPTH, default 8: return-address-stack entries, power of two >= 2.
REQ-006 SHALL have CLK  in  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have RST  in  1  synchronous active-high reset.
REQ-008 SHALL have PC  in  ADDR_WIDTH  fetch address to predict.
REQ-009 SHALL have CACHE_READY  in  1  instruction-cache ready.
REQ-010 SHALL have CACHE_READY_DATA  in  1  data-cache ready; rdy = CACHE_READY & CACHE_READY_DATA.
REQ-011 SHALL have FLUSH  in  1  suppresses all EX-side updates this cycle.
REQ-012 SHALL have EX_BRANCH  in  1  resolved control-transfer instruction in EX.
REQ-013 SHALL have EX_TAKEN  in  1  resolved direction.
REQ-014 SHALL have EX_PC  in  ADDR_WIDTH  address of resolved instruction.
REQ-015 SHALL have EX_TARGET  in  ADDR_WIDTH  resolved taken target.
REQ-016 SHALL have EX_CALL  in  1  resolved instruction is a call.
REQ-017 SHALL have EX_RETURN  in  1  resolved instruction is a return.
REQ-018 SHALL have EX_MISPREDICT  in  1  resolved outcome differed from prediction.
REQ-019 SHALL have PRD_HIT  out  1  valid tag match for PC.
REQ-020 SHALL have PRD_TAKEN  out  1  predicted taken.
REQ-021 SHALL have PRD_ADDR  out  ADDR_WIDTH  predicted next fetch address.
REQ-022 SHALL have BR_COUNT  out  32  resolved-branch counter.
REQ-023 SHALL have MISS_COUNT  out  32  misprediction counter.

Function
REQ-024 SHALL index with PC[IDX+1:2] and tag with PC[ADDR_WIDTH-1:IDX+2]; same split for EX_PC.
REQ-025 SHALL store per way: valid, tag, target, is_return flag, CTR_BITS counter; per set: round-robin victim pointer.
REQ-026 SHALL compute lookup combinationally (zero latency); PRD_HIT = any way valid and tag-equal; at most one way matches.
REQ-027 SHALL drive PRD_ADDR: hit & is_return & RAS nonempty -> RAS top, PRD_TAKEN=1; else hit & counter MSB=1 -> stored target, PRD_TAKEN=1; else PC+4 (modulo 2^ADDR_WIDTH), PRD_TAKEN=0.
REQ-028 SHALL perform updates only when upd = EX_BRANCH & rdy & !FLUSH & !RST; lookup in the update cycle sees pre-update contents; new contents visible next cycle.
REQ-029 SHALL on upd with EX hit: counter +1 if EX_TAKEN else -1, saturating at 0 and 2^CTR_BITS-1; if EX_TAKEN and target differs, overwrite target, set counter to 2^(CTR_BITS-1).
REQ-030 SHALL on upd with EX miss and EX_TAKEN allocate: victim = lowest-numbered invalid way, else set's victim pointer (then pointer +1 mod WAYS); write valid=1, tag, EX_TARGET, is_return=EX_RETURN, counter 2^(CTR_BITS-1); miss with !EX_TAKEN allocates nothing.
REQ-031 SHALL on upd & EX_CALL push EX_PC+4; on upd & EX_RETURN pop; both together replace top without changing depth.
REQ-032 SHALL on push to full RAS overwrite the oldest entry (circular pointer), count saturating at RAS_DEPTH; pop on empty is ignored.
REQ-033 SHALL increment BR_COUNT on upd and MISS_COUNT on upd & EX_MISPREDICT, both wrapping modulo 2^32.
REQ-034 SHALL hold all state when rdy=0 or FLUSH=1.

Reset
REQ-035 SHALL on RST clear all valid bits, victim pointers, RAS pointer and count, BR_COUNT, MISS_COUNT; tag/target arrays need no reset; RST overrides a same-cycle upd; after reset PRD_HIT=0, PRD_TAKEN=0, PRD_ADDR=PC+4.

Verification
REQ-036 SHALL cover cold lookup: reset, PC=0x1000 -> PRD_HIT=0, PRD_ADDR=0x1004.
REQ-037 SHALL cover allocate/train: upd EX_PC=0x1000 taken EX_TARGET=0x2000 -> next cycle PC=0x1000 gives HIT=1, ADDR=0x2000; two not-taken upd -> ADDR=0x1004, counter 0; third not-taken stays 0.
REQ-038 SHALL cover conflict (SETS=256, WAYS=2): taken upd at 0x1000, 0x1400, 0x1800 -> 0x1800 evicts way 0 (0x1000 misses), 0x1400 still hits.
REQ-039 SHALL cover RAS: calls at 0x100, 0x200, return entry allocated at 0x300; PC=0x300 -> ADDR=0x204; pop, then 0x104; 9 pushes at depth 8 keep newest 8.
REQ-040 SHALL cover stall/flush: upd asserted with CACHE_READY=0, or FLUSH=1 -> no table, RAS or counter change.
REQ-041 SHALL cover reset mid-operation: RST with upd in same cycle -> all entries miss, BR_COUNT=0 next cycle.
